// File: rtl/cpu_core_seq.sv
// Two-cycle fetch/execute sequencer for the 8-bit program store.
// Executes against a four-entry register file with a zero flag and stops on a self-jump.
module cpu_core_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] instr,
    output logic [7:0] pc,
    output logic       zflag,
    output logic       halted,
    output logic       retired,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);
    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned RW   = 2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_DEC  = 4'h5;
    localparam logic [3:0] OP_RSV  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_MOVI = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [DW-1:0]   ir, ir_d;
    logic [DW-1:0]   pc_d;
    logic            z_d, halted_d, retired_d;
    logic [DW-1:0]   regs   [NREG];
    logic [DW-1:0]   regs_d [NREG];

    logic [3:0]      opcode;
    logic [RW-1:0]   rd_idx, rs_idx;
    logic [DW-1:0]   rd_val, rs_val;
    logic [DW-1:0]   result;
    logic [DW-1:0]   target;
    logic            wr_en, set_z, take;

    assign opcode = ir[7:4];
    assign rd_idx = ir[3:2];
    assign rs_idx = ir[1:0];
    assign rd_val = regs[rd_idx];
    assign rs_val = regs[rs_idx];

    assign dbg_data = regs[dbg_sel];

    // Decode the latched instruction into a write value, flag update and branch decision.
    always_comb begin
        result = '0;
        wr_en  = 1'b0;
        set_z  = 1'b0;
        take   = 1'b0;
        target = pc + DW'(1);
        if (ir[7:6] == 2'b11) begin
            take   = 1'b1;
            target = {2'b00, ir[5:0]};
        end else begin
            case (opcode)
                OP_ADD:  begin result = rd_val + rs_val; wr_en = 1'b1; set_z = 1'b1; end
                OP_SUB:  begin result = rd_val - rs_val; wr_en = 1'b1; set_z = 1'b1; end
                OP_NOT:  begin result = ~rd_val;         wr_en = 1'b1; set_z = 1'b1; end
                OP_MOVR: begin result = rs_val;          wr_en = 1'b1; end
                OP_DEC:  begin result = rd_val - DW'(1); wr_en = 1'b1; set_z = 1'b1; end
                OP_INC:  begin result = rd_val + DW'(1); wr_en = 1'b1; set_z = 1'b1; end
                OP_MOVI: begin result = {6'b000000, rs_idx}; wr_en = 1'b1; end
                OP_JZ: begin
                    take   = zflag;
                    target = {4'b0000, ir[3:0]};
                end
                OP_JNZ: begin
                    take   = ~zflag;
                    target = {4'b0000, ir[3:0]};
                end
                OP_NOP, OP_RSV, OP_CMP: ;
                default: ;
            endcase
        end
    end

    // Next-state and commit logic; every register holds unless the sequencer advances.
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        pc_d      = pc;
        z_d       = zflag;
        halted_d  = halted;
        retired_d = 1'b0;
        regs_d    = regs;
        if (en) begin
            case (state)
                S_FETCH: begin
                    ir_d    = instr;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    retired_d = 1'b1;
                    if (wr_en) regs_d[rd_idx] = result;
                    if (set_z) z_d = (result == '0);
                    if (opcode == OP_CMP && ir[7:6] != 2'b11) z_d = (rd_val == rs_val);
                    pc_d = take ? target : pc + DW'(1);
                    if (take && target == pc) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        state_d  = S_FETCH;
                    end
                end
                S_HALT: ;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= '0;
            pc      <= '0;
            zflag   <= 1'b0;
            halted  <= 1'b0;
            retired <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state   <= state_d;
            ir      <= ir_d;
            pc      <= pc_d;
            zflag   <= z_d;
            halted  <= halted_d;
            retired <= retired_d;
            for (int i = 0; i < NREG; i++) regs[i] <= regs_d[i];
        end
    end
endmodule

// File: tb/tb_cpu_core_seq.sv
// Directed bench for cpu_core_seq: a bench-side program store feeds instr from pc,
// and each scenario checks hand-computed register, flag and pc values.
module tb_cpu_core_seq;
    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] instr;
    logic [7:0] pc;
    logic       zflag;
    logic       halted;
    logic       retired;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    logic [7:0] mem [256];
    logic       ovr;
    logic [7:0] ovr_val;

    int vectors;
    int miscompares;

    cpu_core_seq dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .instr    (instr),
        .pc       (pc),
        .zflag    (zflag),
        .halted   (halted),
        .retired  (retired),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    assign instr = ovr ? ovr_val : mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic rd_reg(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en  = 1'b1;
        ovr = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic run_retires(input int n, input int budget, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            step();
            cyc++;
            if (retired) got++;
        end
        if (got < n) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got %0d of %0d retires", tag, got, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        clear_mem();
        rst = 1'b1; en = 1'b1; ovr = 1'b1;
        ovr_val = 8'h74; step();
        ovr_val = 8'hC0; step();
        ovr_val = 8'h1F; step();
        vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc got %h want 00", pc); end
        vectors++; if (zflag !== 1'b0) begin miscompares++; $display("FAIL reset_z got %b want 0", zflag); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
        vectors++; if (retired !== 1'b0) begin miscompares++; $display("FAIL reset_retired got %b want 0", retired); end
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reset_R%0d got %h want 00", i, v); end
        end
        ovr = 1'b0;
        rst = 1'b0;
        step();
        vectors++; if (retired !== 1'b0) begin miscompares++; $display("FAIL first_fetch_retired got %b want 0", retired); end
        step();
        vectors++; if (retired !== 1'b1) begin miscompares++; $display("FAIL first_exec_retired got %b want 1", retired); end
        vectors++; if (pc !== 8'h01) begin miscompares++; $display("FAIL first_exec_pc got %h want 01", pc); end
        step();
        vectors++; if (retired !== 1'b0) begin miscompares++; $display("FAIL retired_single_pulse got %b want 0", retired); end
    endtask

    task automatic test_straight();
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h8B; mem[2] = 8'h86;
        mem[3] = 8'h19; mem[4] = 8'h34; mem[5] = 8'hC1;
        do_reset(1);
        run_retires(5, 20, "straight5");
        rd_reg(2'd2, v);
        vectors++; if (v !== 8'h05) begin miscompares++; $display("FAIL straight_R2 got %h want 05", v); end
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'hFD) begin miscompares++; $display("FAIL straight_R1 got %h want fd", v); end
        vectors++; if (zflag !== 1'b0) begin miscompares++; $display("FAIL straight_z got %b want 0", zflag); end
        vectors++; if (pc !== 8'h05) begin miscompares++; $display("FAIL straight_pc5 got %h want 05", pc); end
        run_retires(1, 6, "straight_jmp");
        vectors++; if (pc !== 8'h01) begin miscompares++; $display("FAIL straight_jmp_pc got %h want 01", pc); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL straight_halted got %b want 0", halted); end
        run_retires(1, 6, "straight_loop");
        rd_reg(2'd2, v);
        vectors++; if (v !== 8'h03) begin miscompares++; $display("FAIL straight_loop_R2 got %h want 03", v); end
        vectors++; if (pc !== 8'h02) begin miscompares++; $display("FAIL straight_loop_pc got %h want 02", pc); end
    endtask

    task automatic test_cmp_loop();
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h8F; mem[1] = 8'h8B; mem[2] = 8'h85; mem[3] = 8'h1E;
        mem[4] = 8'h74; mem[5] = 8'h97; mem[6] = 8'hB4; mem[7] = 8'hFF;
        do_reset(1);
        run_retires(4, 16, "cmp_setup");
        rd_reg(2'd3, v);
        vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL cmp_R3 got %h want 06", v); end
        run_retires(3, 12, "cmp_iter1");
        vectors++; if (pc !== 8'h04) begin miscompares++; $display("FAIL cmp_backedge_pc got %h want 04", pc); end
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'h02) begin miscompares++; $display("FAIL cmp_iter1_R1 got %h want 02", v); end
        run_retires(12, 48, "cmp_iters");
        vectors++; if (pc !== 8'h07) begin miscompares++; $display("FAIL cmp_exit_pc got %h want 07", pc); end
        vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL cmp_exit_z got %b want 1", zflag); end
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL cmp_exit_R1 got %h want 06", v); end
        run_retires(1, 6, "cmp_jmp63");
        vectors++; if (pc !== 8'h3F) begin miscompares++; $display("FAIL cmp_jmp63_pc got %h want 3f", pc); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL cmp_jmp63_halted got %b want 0", halted); end
    endtask

    task automatic test_halt();
        logic [7:0] v;
        int seen;
        clear_mem();
        mem[2] = 8'hC2;
        do_reset(1);
        run_retires(2, 8, "halt_pre");
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early got %b want 0", halted); end
        run_retires(1, 6, "halt_jump");
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag got %b want 1", halted); end
        vectors++; if (retired !== 1'b1) begin miscompares++; $display("FAIL halt_with_retire got %b want 1", retired); end
        vectors++; if (pc !== 8'h02) begin miscompares++; $display("FAIL halt_pc got %h want 02", pc); end
        ovr = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            ovr_val = (i % 2 == 0) ? 8'h74 : 8'hC5;
            step();
            if (retired) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL halt_no_retire got %0d want 0", seen); end
        vectors++; if (pc !== 8'h02) begin miscompares++; $display("FAIL halt_pc_frozen got %h want 02", pc); end
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL halt_R1 got %h want 00", v); end
        do_reset(1);
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_cleared got %b want 0", halted); end
    endtask

    task automatic test_wrap_arith();
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h90; mem[2] = 8'h50; mem[3] = 8'h70;
        mem[4] = 8'h8E; mem[5] = 8'h1F; mem[6] = 8'h47; mem[7] = 8'h27;
        mem[8] = 8'h60;
        do_reset(1);
        run_retires(2, 8, "wa_cmp");
        vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL wa_cmp_z got %b want 1", zflag); end
        run_retires(1, 4, "wa_dec");
        rd_reg(2'd0, v);
        vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL wa_dec_R0 got %h want ff", v); end
        vectors++; if (zflag !== 1'b0) begin miscompares++; $display("FAIL wa_dec_z got %b want 0", zflag); end
        run_retires(1, 4, "wa_inc");
        rd_reg(2'd0, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL wa_inc_R0 got %h want 00", v); end
        vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL wa_inc_z got %b want 1", zflag); end
        run_retires(1, 4, "wa_movi");
        vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL wa_movi_keeps_z got %b want 1", zflag); end
        run_retires(1, 4, "wa_add_self");
        rd_reg(2'd3, v);
        vectors++; if (v !== 8'h04) begin miscompares++; $display("FAIL wa_add_self_R3 got %h want 04", v); end
        vectors++; if (zflag !== 1'b0) begin miscompares++; $display("FAIL wa_add_z got %b want 0", zflag); end
        run_retires(1, 4, "wa_movr");
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'h04) begin miscompares++; $display("FAIL wa_movr_R1 got %h want 04", v); end
        run_retires(2, 8, "wa_sub_rsv");
        rd_reg(2'd1, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL wa_sub_R1 got %h want 00", v); end
        vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL wa_rsv_z got %b want 1", zflag); end
        vectors++; if (pc !== 8'h09) begin miscompares++; $display("FAIL wa_pc9 got %h want 09", pc); end
        run_retires(246, 1000, "wa_walk");
        vectors++; if (pc !== 8'hFF) begin miscompares++; $display("FAIL wa_pc255 got %h want ff", pc); end
        run_retires(1, 4, "wa_wrap");
        vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL wa_wrap_pc got %h want 00", pc); end
    endtask

    task automatic test_stall_rst();
        logic [7:0] v;
        int seen;
        clear_mem();
        mem[0] = 8'h8D; mem[1] = 8'h1F;
        do_reset(1);
        en = 1'b0; ovr = 1'b1; ovr_val = 8'h8F; seen = 0;
        repeat (4) begin step(); if (retired) seen++; end
        vectors++; if (seen !== 0 || pc !== 8'h00) begin miscompares++; $display("FAIL stall_fetch got seen=%0d pc=%h want 0/00", seen, pc); end
        ovr = 1'b0; en = 1'b1;
        step();
        vectors++; if (retired !== 1'b0) begin miscompares++; $display("FAIL stall_fetch_edge got %b want 0", retired); end
        en = 1'b0; ovr = 1'b1; ovr_val = 8'h8F; seen = 0;
        repeat (4) begin step(); if (retired) seen++; end
        rd_reg(2'd3, v);
        vectors++; if (seen !== 0 || v !== 8'h00 || pc !== 8'h00) begin miscompares++; $display("FAIL stall_exec got seen=%0d R3=%h pc=%h want 0/00/00", seen, v, pc); end
        ovr = 1'b0; en = 1'b1;
        step();
        rd_reg(2'd3, v);
        vectors++; if (retired !== 1'b1 || v !== 8'h01) begin miscompares++; $display("FAIL stall_resume got ret=%b R3=%h want 1/01", retired, v); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_reg(2'd3, v);
        vectors++; if (v !== 8'h00 || pc !== 8'h00 || retired !== 1'b0) begin miscompares++; $display("FAIL rst_mid_exec got R3=%h pc=%h ret=%b want 00/00/0", v, pc, retired); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b1; ovr = 1'b0; ovr_val = 8'h00; dbg_sel = 2'd0;
        clear_mem();
        test_reset();
        test_straight();
        test_cmp_loop();
        test_halt();
        test_wrap_arith();
        test_stall_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_core_seq.md
# cpu_core_seq

Fetch/decode/execute sequencer that consumes the 8-bit instruction stream from the program store. It drives the store's line-number input, latches the returned instruction word and executes it against a four-entry 8-bit register file with a zero flag. Each instruction runs in a fixed two-cycle fetch/execute loop. It is the consumer side of the program-store interface and sits between that store and the board-level debug/LED logic.

## Interface

Parameters:
- None. All widths are fixed: 8-bit PC, 8-bit instruction, 8-bit registers.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  run enable; when low, all state holds
- `instr`  in  8  instruction word returned by the program store for `pc` (combinational, same cycle)
- `pc`  out  8  registered program counter; drives the program store's line number
- `zflag`  out  1  registered zero flag
- `halted`  out  1  registered; high once a self-jump executes
- `retired`  out  1  registered; one-cycle pulse per committed instruction
- `dbg_sel`  in  2  register index for the debug read
- `dbg_data`  out  8  combinational read of R[`dbg_sel`]

## Operation

Instruction decode:
- `[7:4]` is the opcode, `[3:2]` is rd, `[1:0]` is rs or the 2-bit immediate.
- 0000 NOP.
- 0001 ADD: rd = rd + rs.
- 0010 SUB: rd = rd - rs.
- 0011 NOT: rd = ~rd.
- 0100 MOVR: rd = rs.
- 0101 DEC: rd = rd - 1.
- 0110 reserved; treated as NOP.
- 0111 INC: rd = rd + 1.
- 1000 MOVI: rd = {6'b0, imm}.
- 1001 CMP: Z = (rd == rs); no register write.
- 1010 JZ: if Z, pc = {4'b0, instr[3:0]}.
- 1011 JNZ: if !Z, pc = {4'b0, instr[3:0]}.
- `11xxxxxx` JMP: pc = {2'b0, instr[5:0]}.

Arithmetic and flag rules:
- All arithmetic is mod 256; no carry or overflow flag.
- Z = (result == 0) after ADD, SUB, NOT, DEC and INC.
- MOVR, MOVI, NOP and the jumps leave Z unchanged.
- When rd == rs, reads use pre-write values (e.g. ADD R1,R1 doubles R1).

State machine: FETCH, EXEC, HALT.
- FETCH, en=1: ir <= instr; go to EXEC.
- EXEC, en=1: commit the register, flag and pc updates; pulse `retired`.
  - Taken jump whose target == current pc: set `halted`; go to HALT.
  - Otherwise: go to FETCH.
- Next pc is either the jump target or pc+1. pc+1 wraps 255 to 0.
- Untaken JZ/JNZ behaves as pc+1.
- HALT: no further fetch or commit. Exit only by `rst`.
- en=0 in any state: state, ir, regs, Z and pc all hold; `retired`=0.

Reset values (`rst`=1 at an edge):
- pc=0, ir=0, R0..R3=0, Z=0, halted=0, retired=0, state=FETCH.
- Reset overrides `en` and any in-flight EXEC; a partially executed instruction does not commit.

## Timing

- `pc` is stable for the whole FETCH cycle. `instr` must be valid combinationally within that cycle; it is sampled at the FETCH edge.
- Reset released before edge E0:
  - E0 latches ir = store[0].
  - E1 commits it: regs/Z/pc/`retired` visible after E1.
- Steady throughput: one instruction per 2 enabled cycles.
- `retired` is high for exactly the cycle after each EXEC edge. Never two consecutive cycles.
- `dbg_data` reflects a register write in the cycle after the EXEC edge. No bypass.
- `halted` rises together with the `retired` pulse of the self-jump.

## Test plan

- **Reset:** hold `rst` 3 cycles with en=1 and arbitrary `instr`. Expect pc=0, all regs 0, zflag=0, halted=0, retired=0. Then deassert and check the first `retired` arrives 2 cycles later.
- **Straight-line program:**
  - Program: 0x00, 0x8B, 0x86, 0x19, 0x34, 0xC1.
  - After 5 retires: R2=0x05, R1=0xFD, zflag=0.
  - Sixth instruction: pc goes to 1, R2 is rewritten to 3, then the loop repeats indefinitely.
- **Compare loop:**
  - Program: 0x8F, 0x8B, 0x85, 0x1E, 0x74, 0x97, 0xB4, 0xFF.
  - Expect R3=6, a loop exit when R1=6, zflag=1 at exit, pc=7.
  - At 0xFF: JMP 63 (≠7), so no halt.
- **Self-jump halt:** store[2]=0xC2. Expect halted=1 after its EXEC and pc frozen at 2. Further `instr` changes have no effect and `retired` stays 0 until `rst`.
- **Wrap and arithmetic:**
  - MOVI R0,0 then DEC R0: R0=0xFF, zflag=0.
  - INC R0: R0=0x00, zflag=1.
  - A NOP stream from pc=255 wraps pc to 0.
- **Stall and reset mid-op:**
  - Drop `en` in FETCH and in EXEC for 4 cycles each: no state change, no `retired`.
  - Assert `rst` on the EXEC edge of ADD: the destination register stays 0 and pc=0.
